// File: rtl/jesd_looback_ctrl_if.sv
// Control/status bundle for the JESD RX loopback sequencer.
// The master side is software/datapath glue; the slave side is the sequencer.
interface jesd_looback_ctrl_if;
  logic        cfg_loopback_req;
  logic        frame_start;
  logic        dma_in_valid;
  logic        err_clr;
  logic        loop_sel;
  logic        adc_mute;
  logic        busy;
  logic [2:0]  state;
  logic        err_timeout;
  logic        err_starve;
  logic [15:0] switch_cnt;

  modport master (
    output cfg_loopback_req, frame_start, dma_in_valid, err_clr,
    input  loop_sel, adc_mute, busy, state, err_timeout, err_starve, switch_cnt
  );

  modport slave (
    input  cfg_loopback_req, frame_start, dma_in_valid, err_clr,
    output loop_sel, adc_mute, busy, state, err_timeout, err_starve, switch_cnt
  );
endinterface

// File: rtl/jesd_looback_ctrl.sv
// JESD RX-path loopback sequencer (rx_link_clk domain).
// Switches the loopback mux select on a frame boundary and mutes the ADC
// outputs for FLUSH_CYC cycles around every switch so half-built samples from
// the width converter never propagate downstream.
// Optional feature macro: JESD_LOOPBACK_WDOG_EN adds a DMA starvation watchdog
// that forces an exit from loopback and locks out re-entry until the request
// is dropped.
module jesd_looback_ctrl #(
  parameter int FLUSH_CYC = 16,
  parameter int TIMEOUT   = 30720,
  parameter int WDOG_CYC  = 1024
) (
  input  logic                rx_link_clk,
  input  logic                rst,
  jesd_looback_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    THRU      = 3'd0,
    ARM_ON    = 3'd1,
    FLUSH_ON  = 3'd2,
    LOOP      = 3'd3,
    ARM_OFF   = 3'd4,
    FLUSH_OFF = 3'd5
  } state_e;

  localparam int            FW         = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYC - 1);
  localparam logic [15:0]   TMO_LAST   = 16'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [15:0]   wait_q, wait_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [15:0]   switch_q, switch_d;
  logic          err_timeout_q, err_timeout_d;
  logic          loop_sel_q, loop_sel_d;
  logic          adc_mute_q, adc_mute_d;
  logic          busy_q, busy_d;
  logic          timeout_set;
  logic          starve_trip;
  logic          lockout;

`ifdef JESD_LOOPBACK_WDOG_EN
  localparam logic [15:0] WD_LAST = 16'(WDOG_CYC - 1);

  logic [15:0] wd_q, wd_d;
  logic        lockout_q, lockout_d;
  logic        err_starve_q, err_starve_d;

  // Count consecutive idle DMA cycles while looped back; trip at WDOG_CYC.
  always_comb begin
    wd_d         = wd_q;
    starve_trip  = 1'b0;
    lockout_d    = lockout_q;
    err_starve_d = err_starve_q;
    if (state_q != LOOP || bus.dma_in_valid) begin
      wd_d = '0;
    end else if (wd_q == WD_LAST) begin
      starve_trip = 1'b1;
      wd_d        = '0;
    end else begin
      wd_d = wd_q + 16'd1;
    end
    if (starve_trip) begin
      lockout_d = 1'b1;
    end else if (state_q == THRU && !bus.cfg_loopback_req) begin
      lockout_d = 1'b0;
    end
    if (starve_trip) begin
      err_starve_d = 1'b1;
    end else if (bus.err_clr) begin
      err_starve_d = 1'b0;
    end
  end

  // Watchdog, lockout and starvation flag registers.
  always_ff @(posedge rx_link_clk) begin
    if (rst) begin
      wd_q         <= '0;
      lockout_q    <= 1'b0;
      err_starve_q <= 1'b0;
    end else begin
      wd_q         <= wd_d;
      lockout_q    <= lockout_d;
      err_starve_q <= err_starve_d;
    end
  end

  assign lockout        = lockout_q;
  assign bus.err_starve = err_starve_q;
`else
  logic unused_wdog;

  assign starve_trip    = 1'b0;
  assign lockout        = 1'b0;
  assign bus.err_starve = 1'b0;
  assign unused_wdog    = bus.dma_in_valid ^ (WDOG_CYC == 0);
`endif

  // Next-state, timers, switch counter and registered output decode.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    flush_d     = flush_q;
    switch_d    = switch_q;
    timeout_set = 1'b0;
    case (state_q)
      THRU: begin
        if (bus.cfg_loopback_req && !lockout) begin
          state_d = ARM_ON;
          wait_d  = '0;
        end
      end
      ARM_ON: begin
        if (bus.frame_start) begin
          state_d = FLUSH_ON;
          flush_d = FLUSH_LOAD;
        end else if (!bus.cfg_loopback_req) begin
          state_d = THRU;
        end else if (wait_q == TMO_LAST) begin
          state_d     = THRU;
          timeout_set = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      FLUSH_ON: begin
        if (flush_q == '0) begin
          state_d  = LOOP;
          switch_d = switch_q + 16'd1;
        end else begin
          flush_d = flush_q - FW'(1);
        end
      end
      LOOP: begin
        if (starve_trip) begin
          state_d = FLUSH_OFF;
          flush_d = FLUSH_LOAD;
        end else if (!bus.cfg_loopback_req) begin
          state_d = ARM_OFF;
          wait_d  = '0;
        end
      end
      ARM_OFF: begin
        if (bus.frame_start) begin
          state_d = FLUSH_OFF;
          flush_d = FLUSH_LOAD;
        end else if (wait_q == TMO_LAST) begin
          state_d     = FLUSH_OFF;
          flush_d     = FLUSH_LOAD;
          timeout_set = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      FLUSH_OFF: begin
        if (flush_q == '0) begin
          state_d = THRU;
        end else begin
          flush_d = flush_q - FW'(1);
        end
      end
      default: begin
        state_d = THRU;
      end
    endcase

    if (timeout_set) begin
      err_timeout_d = 1'b1;
    end else if (bus.err_clr) begin
      err_timeout_d = 1'b0;
    end else begin
      err_timeout_d = err_timeout_q;
    end

    loop_sel_d = (state_d == FLUSH_ON) || (state_d == LOOP) || (state_d == ARM_OFF);
    adc_mute_d = (state_d == FLUSH_ON) || (state_d == FLUSH_OFF);
    busy_d     = (state_d == ARM_ON) || (state_d == FLUSH_ON) ||
                 (state_d == ARM_OFF) || (state_d == FLUSH_OFF);
  end

  // State, timers and glitch-free registered outputs.
  always_ff @(posedge rx_link_clk) begin
    if (rst) begin
      state_q       <= THRU;
      wait_q        <= '0;
      flush_q       <= '0;
      switch_q      <= '0;
      err_timeout_q <= 1'b0;
      loop_sel_q    <= 1'b0;
      adc_mute_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      flush_q       <= flush_d;
      switch_q      <= switch_d;
      err_timeout_q <= err_timeout_d;
      loop_sel_q    <= loop_sel_d;
      adc_mute_q    <= adc_mute_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.loop_sel    = loop_sel_q;
  assign bus.adc_mute    = adc_mute_q;
  assign bus.busy        = busy_q;
  assign bus.state       = state_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.switch_cnt  = switch_q;

endmodule

// File: tb/tb_jesd_looback_ctrl.sv
// Self-checking bench for jesd_looback_ctrl (FLUSH_CYC=16, TIMEOUT=100,
// WDOG_CYC=8). Watchdog sequence is built when JESD_LOOPBACK_WDOG_EN is set.
module tb_jesd_looback_ctrl;
  localparam int FLUSH = 16;
  localparam int TMO   = 100;
  localparam int WD    = 8;

  localparam logic [2:0] S_THRU = 3'd0, S_ARMON = 3'd1, S_FLON = 3'd2,
                         S_LOOP = 3'd3, S_ARMOFF = 3'd4, S_FLOFF = 3'd5;

  typedef struct {
    logic        req, fs, clr, valid, r;
    logic [2:0]  st;
    logic        eT;
    logic [15:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[7];

  jesd_looback_ctrl_if bus();

  jesd_looback_ctrl #(.FLUSH_CYC(FLUSH), .TIMEOUT(TMO), .WDOG_CYC(WD)) dut (
    .rx_link_clk (clk),
    .rst         (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic req, input logic fs, input logic clr,
                               input logic valid, input logic r);
    bus.cfg_loopback_req = req;
    bus.frame_start      = fs;
    bus.err_clr          = clr;
    bus.dma_in_valid     = valid;
    rst                  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] st, input logic eT,
                             input logic eS, input logic [15:0] cnt);
    logic sel, mute, bsy;
    logic [23:0] expv, actv;
    sel  = (st == S_FLON) || (st == S_LOOP) || (st == S_ARMOFF);
    mute = (st == S_FLON) || (st == S_FLOFF);
    bsy  = (st == S_ARMON) || (st == S_FLON) || (st == S_ARMOFF) || (st == S_FLOFF);
    expv = {sel, mute, bsy, st, eT, eS, cnt};
    actv = {bus.loop_sel, bus.adc_mute, bus.busy, bus.state, bus.err_timeout,
            bus.err_starve, bus.switch_cnt};
    checks++;
    if (actv !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got sel=%b mute=%b busy=%b state=%0d errT=%b errS=%b cnt=%0d, expected sel=%b mute=%b busy=%b state=%0d errT=%b errS=%b cnt=%0d",
               name, actv[23], actv[22], actv[21], actv[20:18], actv[17], actv[16], actv[15:0],
               sel, mute, bsy, st, eT, eS, cnt);
    end
  endtask

  task automatic step(input logic req, input logic fs, input logic clr, input logic valid,
                      input logic r, input string name, input logic [2:0] st,
                      input logic eT, input logic eS, input logic [15:0] cnt);
    applyStimulus(req, fs, clr, valid, r);
    checkOutput(name, st, eT, eS, cnt);
  endtask

  initial begin
    // Reset, request latency, same-cycle frame_start ignored, abort from ARM_ON
    tbl[0] = '{req:0, fs:0, clr:0, valid:1, r:1, st:S_THRU,  eT:0, cnt:16'd0};
    tbl[1] = '{req:0, fs:0, clr:0, valid:1, r:0, st:S_THRU,  eT:0, cnt:16'd0};
    tbl[2] = '{req:1, fs:1, clr:0, valid:1, r:0, st:S_ARMON, eT:0, cnt:16'd0};
    tbl[3] = '{req:1, fs:0, clr:0, valid:1, r:0, st:S_ARMON, eT:0, cnt:16'd0};
    tbl[4] = '{req:0, fs:0, clr:0, valid:1, r:0, st:S_THRU,  eT:0, cnt:16'd0};
    tbl[5] = '{req:1, fs:0, clr:0, valid:1, r:0, st:S_ARMON, eT:0, cnt:16'd0};
    tbl[6] = '{req:1, fs:1, clr:0, valid:1, r:0, st:S_FLON,  eT:0, cnt:16'd0};

    for (int i = 0; i < 7; i++) begin
      step(tbl[i].req, tbl[i].fs, tbl[i].clr, tbl[i].valid, tbl[i].r,
           $sformatf("vec%0d", i), tbl[i].st, tbl[i].eT, 1'b0, tbl[i].cnt);
    end

    // Flush window with request toggling; LOOP still entered, ARM_OFF next cycle
    for (int i = 0; i < FLUSH - 1; i++)
      step((i % 3) != 0, 0, 0, 1, 0, "flush_on", S_FLON, 0, 0, 16'd0);
    step(0, 0, 0, 1, 0, "loop_entry", S_LOOP, 0, 0, 16'd1);
    step(0, 0, 0, 1, 0, "arm_off_entry", S_ARMOFF, 0, 0, 16'd1);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 1, 0, "arm_off_wait", S_ARMOFF, 0, 0, 16'd1);
    step(0, 1, 0, 1, 0, "flush_off_entry", S_FLOFF, 0, 0, 16'd1);
    for (int i = 0; i < FLUSH - 1; i++)
      step(1, 0, 0, 1, 0, "flush_off", S_FLOFF, 0, 0, 16'd1);
    step(0, 0, 0, 1, 0, "thru_return", S_THRU, 0, 0, 16'd1);

    // ARM_ON timeout, err_clr, and set-wins-over-clear
    step(1, 0, 0, 1, 0, "tmo_arm", S_ARMON, 0, 0, 16'd1);
    for (int i = 1; i < TMO; i++)
      step(1, 0, 0, 1, 0, "tmo_wait", S_ARMON, 0, 0, 16'd1);
    step(1, 0, 0, 1, 0, "tmo_expire", S_THRU, 1, 0, 16'd1);
    step(0, 0, 1, 1, 0, "err_clr", S_THRU, 0, 0, 16'd1);
    step(1, 0, 0, 1, 0, "tmo2_arm", S_ARMON, 0, 0, 16'd1);
    for (int i = 1; i < TMO; i++)
      step(1, 0, 0, 1, 0, "tmo2_wait", S_ARMON, 0, 0, 16'd1);
    step(1, 0, 1, 1, 0, "tmo_set_beats_clr", S_THRU, 1, 0, 16'd1);
    step(0, 0, 1, 1, 0, "err_clr2", S_THRU, 0, 0, 16'd1);

    // frame_start on the terminal timeout cycle wins, no error
    step(1, 0, 0, 1, 0, "tmo3_arm", S_ARMON, 0, 0, 16'd1);
    for (int i = 1; i < TMO; i++)
      step(1, 0, 0, 1, 0, "tmo3_wait", S_ARMON, 0, 0, 16'd1);
    step(1, 1, 0, 1, 0, "fs_beats_tmo", S_FLON, 0, 0, 16'd1);
    for (int i = 0; i < FLUSH - 1; i++)
      step(1, 0, 0, 1, 0, "flush_on2", S_FLON, 0, 0, 16'd1);
    step(1, 0, 0, 1, 0, "loop_entry2", S_LOOP, 0, 0, 16'd2);
    step(1, 0, 0, 1, 0, "loop_hold", S_LOOP, 0, 0, 16'd2);

    // ARM_OFF timeout still completes the exit
    step(0, 0, 0, 1, 0, "arm_off2", S_ARMOFF, 0, 0, 16'd2);
    for (int i = 1; i < TMO; i++)
      step(0, 0, 0, 1, 0, "arm_off2_wait", S_ARMOFF, 0, 0, 16'd2);
    step(0, 0, 0, 1, 0, "arm_off_tmo", S_FLOFF, 1, 0, 16'd2);
    for (int i = 0; i < FLUSH - 1; i++)
      step(0, 0, 0, 1, 0, "flush_off2", S_FLOFF, 1, 0, 16'd2);
    step(0, 0, 0, 1, 0, "thru_return2", S_THRU, 1, 0, 16'd2);

    // Reset in the middle of FLUSH_ON
    step(1, 0, 0, 1, 0, "rst_arm", S_ARMON, 1, 0, 16'd2);
    step(1, 1, 0, 1, 0, "rst_flush", S_FLON, 1, 0, 16'd2);
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 1, 0, "rst_flush_wait", S_FLON, 1, 0, 16'd2);
    step(1, 0, 0, 1, 1, "mid_reset", S_THRU, 0, 0, 16'd0);
    step(0, 0, 0, 1, 0, "post_reset", S_THRU, 0, 0, 16'd0);

    // Enter LOOP, then starve the DMA valid
    step(1, 0, 0, 1, 0, "wd_arm", S_ARMON, 0, 0, 16'd0);
    step(1, 1, 0, 1, 0, "wd_flush", S_FLON, 0, 0, 16'd0);
    for (int i = 0; i < FLUSH - 1; i++)
      step(1, 0, 0, 1, 0, "wd_flush_wait", S_FLON, 0, 0, 16'd0);
    step(1, 0, 0, 1, 0, "wd_loop", S_LOOP, 0, 0, 16'd1);
`ifdef JESD_LOOPBACK_WDOG_EN
    for (int i = 0; i < WD - 1; i++)
      step(1, 0, 0, 0, 0, "wd_idle", S_LOOP, 0, 0, 16'd1);
    step(1, 0, 0, 0, 0, "wd_trip", S_FLOFF, 0, 1, 16'd1);
    for (int i = 0; i < FLUSH - 1; i++)
      step(1, 0, 0, 0, 0, "wd_flush_off", S_FLOFF, 0, 1, 16'd1);
    step(1, 0, 0, 1, 0, "wd_thru", S_THRU, 0, 1, 16'd1);
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 1, 0, "wd_lockout", S_THRU, 0, 1, 16'd1);
    step(0, 0, 0, 1, 0, "wd_unlock", S_THRU, 0, 1, 16'd1);
    step(1, 0, 0, 1, 0, "wd_rearm", S_ARMON, 0, 1, 16'd1);
    step(0, 0, 1, 1, 0, "wd_err_clr", S_THRU, 0, 0, 16'd1);
`else
    for (int i = 0; i < WD + 4; i++)
      step(1, 0, 0, 0, 0, "no_wdog_idle", S_LOOP, 0, 0, 16'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jesd_looback_ctrl.md
# jesd_looback_ctrl

Sequencer for the JESD RX-path loopback mux, running in the `rx_link_clk` domain. It turns the software loopback request into a glitch-free switch of the mux select, aligned to a frame boundary. Around each switch it mutes the ADC-side outputs for a fixed flush window, so partial samples from the 32-to-16 width converter never reach `harden_rx_top`. It also reports timeouts, starvation and a switch count.

## Interface
Parameters:
- `FLUSH_CYC`, default 16: mute window length in cycles, at least 1.
- `TIMEOUT`, default 30720: maximum cycles to wait for `frame_start` in either ARM state, range 1..65535.
- `WDOG_CYC`, default 1024: maximum consecutive cycles without `dma_in_valid` while in LOOP, range 1..65535. Used only with `JESD_LOOPBACK_WDOG_EN`.

Ports:
- `rx_link_clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `cfg_loopback_req` in 1: level; 1 requests loopback.
- `frame_start` in 1: single-cycle frame-boundary pulse.
- `dma_in_valid` in 1: TX DMA data valid, already in `rx_link_clk` domain.
- `err_clr` in 1: pulse; clears the sticky error flags.
- `loop_sel` out 1: mux select; 1 selects the looped-back TX data.
- `adc_mute` out 1: 1 forces the ADC outputs to zero downstream.
- `busy` out 1: 1 in ARM_ON, FLUSH_ON, ARM_OFF and FLUSH_OFF.
- `state` out 3: current state code.
- `err_timeout` out 1: sticky flag, boundary timeout.
- `err_starve` out 1: sticky flag, watchdog exit.
- `switch_cnt` out 16: number of entries into LOOP; wraps at 0xFFFF to 0.

## Operation
State codes: THRU=0, ARM_ON=1, FLUSH_ON=2, LOOP=3, ARM_OFF=4, FLUSH_OFF=5.

Outputs are decoded from the registered state (Moore), so they change one cycle after the deciding input:
- THRU: `loop_sel`=0, `adc_mute`=0.
- ARM_ON: `loop_sel`=0, `adc_mute`=0.
- FLUSH_ON: `loop_sel`=1, `adc_mute`=1.
- LOOP: `loop_sel`=1, `adc_mute`=0.
- ARM_OFF: `loop_sel`=1, `adc_mute`=0.
- FLUSH_OFF: `loop_sel`=0, `adc_mute`=1.

Transitions:
- THRU → ARM_ON when `cfg_loopback_req`=1 (and no lockout). The wait timer clears.
- ARM_ON → FLUSH_ON on `frame_start`. The flush counter loads `FLUSH_CYC`-1.
- ARM_ON → THRU if `cfg_loopback_req` drops, with no error.
- ARM_ON → THRU when the wait timer reaches `TIMEOUT`-1 with no `frame_start`. Sets `err_timeout`.
- FLUSH_ON → LOOP when the flush counter reaches 0. `switch_cnt` increments on this transition.
- LOOP → ARM_OFF when `cfg_loopback_req`=0. The wait timer clears.
- ARM_OFF → FLUSH_OFF on `frame_start`.
- ARM_OFF → FLUSH_OFF on timeout. Sets `err_timeout`. Leaving loopback always completes.
- FLUSH_OFF → THRU when the flush counter reaches 0.

Boundary rules:
- Changes to `cfg_loopback_req` during FLUSH_ON or FLUSH_OFF are ignored until the flush completes. The level is then re-evaluated in the destination state.
- `frame_start` in the same cycle that THRU sees the request has no effect. Alignment uses only a pulse sampled while in ARM_ON.
- `frame_start` and the timeout terminal count in the same cycle: `frame_start` wins and no error is set.
- `err_clr` and an error-set event in the same cycle: the set wins.
- Reset mid-operation: all state is discarded and the block is in THRU on the next cycle. `loop_sel`, `adc_mute`, `busy`, `err_*` and `switch_cnt` are 0, and `state` is 0.

## Timing
- `frame_start` sampled at cycle n in ARM_ON:
  - `loop_sel`=1 and `adc_mute`=1 at n+1.
  - `adc_mute`=0 at n+1+`FLUSH_CYC`.
  - `switch_cnt` updates at n+1+`FLUSH_CYC`.
- THRU→ARM_ON latency: 1 cycle after the request is sampled.
- Timeout: ARM entered at cycle m with no pulse → leave the ARM state and set `err_timeout` at m+`TIMEOUT`.
- All flag and counter outputs are registered.

## Configuration
Macro `JESD_LOOPBACK_WDOG_EN`.

With the macro defined:
- In LOOP, a counter tracks consecutive cycles with `dma_in_valid`=0. It clears on `dma_in_valid`=1 and on LOOP entry.
- When it reaches `WDOG_CYC`, the block sets `err_starve` and goes directly to FLUSH_OFF, without waiting for a boundary.
- A lockout flag is then set and blocks THRU→ARM_ON. It clears when `cfg_loopback_req`=0 is sampled in THRU.

Without the macro:
- No watchdog logic and no lockout.
- `err_starve` is tied to 0.

## Test plan
- Reset, then request=1, then `frame_start` at cycle 10 (`FLUSH_CYC`=16) → `loop_sel`=1 and `adc_mute`=1 at cycle 11; `adc_mute`=0 and `switch_cnt`=1 at cycle 27.
- In LOOP, request=0, then `frame_start` → FLUSH_OFF for 16 cycles with `loop_sel`=0 and `adc_mute`=1, then THRU with `busy`=0.
- Request=1 with no `frame_start` (`TIMEOUT`=100) → return to THRU after 100 cycles; `err_timeout`=1. `err_clr` → 0. `err_clr` on the same cycle as a new timeout → `err_timeout` stays 1.
- Toggle the request to 0 during FLUSH_ON → LOOP is still entered, then ARM_OFF one cycle later. Assert `rst` in FLUSH_ON → all outputs 0 on the next cycle.
- With `JESD_LOOPBACK_WDOG_EN` and `WDOG_CYC`=8, hold `dma_in_valid`=0 in LOOP → FLUSH_OFF after 8 cycles; `err_starve`=1. Request held at 1 stays in THRU until it drops and rises again.
